sram_address: RTL and testbench



---
 rtl/sram_address.sv | 107 ++++++++++
 tb/tb_sram_address.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_address.sv
// sram_address: one 32-bit word-line row of the data SRAM.
// Per-byte write enables, registered read-out, and pulse edge detection
// on the system clock. Optional per-byte even parity is enabled by
// defining SRAMADDRESS_PARITY_EN, which also adds the flg_parity_err port.
module sram_address (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        WL,
    input  logic [3:0]  byte_sel,
    input  logic [31:0] datain,
    input  logic        read_pulse,
    input  logic        write_pulse,
    output logic [31:0] dataout,
`ifdef SRAMADDRESS_PARITY_EN
    output logic        flg_parity_err,
`endif
    output logic        flg_complete
);

    logic [31:0] mem_word;
    logic        read_pulse_q;
    logic        write_pulse_q;
    logic        write_evt;
    logic        read_evt;
    logic [31:0] word_next;
    logic [31:0] read_word;

    // Rising-edge detection gated by the word-line; a write wins over a read.
    always_comb begin
        write_evt = write_pulse & ~write_pulse_q & WL;
        read_evt  = read_pulse & ~read_pulse_q & WL & ~write_evt;
    end

    // Byte-merged write data and byte-masked read data.
    always_comb begin
        word_next = mem_word;
        read_word = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (byte_sel[k]) begin
                word_next[8*k +: 8] = datain[8*k +: 8];
                read_word[8*k +: 8] = mem_word[8*k +: 8];
            end
        end
    end

    // Edge registers track their pulses regardless of the word-line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_pulse_q  <= 1'b0;
            write_pulse_q <= 1'b0;
        end else begin
            read_pulse_q  <= read_pulse;
            write_pulse_q <= write_pulse;
        end
    end

    // Storage word, read register and completion strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_word     <= '0;
            dataout      <= '0;
            flg_complete <= 1'b0;
        end else begin
            flg_complete <= write_evt | read_evt;
            if (write_evt) begin
                mem_word <= word_next;
            end
            if (read_evt) begin
                dataout <= read_word;
            end
        end
    end

`ifdef SRAMADDRESS_PARITY_EN
    logic [3:0] par_bits;
    logic [3:0] par_next;
    logic [3:0] par_mismatch;

    // Even parity of incoming bytes and mismatch against stored parity.
    always_comb begin
        par_next     = par_bits;
        par_mismatch = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (byte_sel[k]) begin
                par_next[k] = ^datain[8*k +: 8];
            end
            par_mismatch[k] = par_bits[k] ^ (^mem_word[8*k +: 8]);
        end
    end

    // Parity bits follow their bytes; the error flag updates with dataout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bits       <= '0;
            flg_parity_err <= 1'b0;
        end else begin
            if (write_evt) begin
                par_bits <= par_next;
            end
            if (read_evt) begin
                flg_parity_err <= |(byte_sel & par_mismatch);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_address.sv
// Self-checking bench for sram_address with a byte-array reference model.
module tb_sram_address;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WL = 1'b0;
    logic [3:0]  byte_sel = '0;
    logic [31:0] datain = '0;
    logic        read_pulse = 1'b0;
    logic        write_pulse = 1'b0;
    logic [31:0] dataout;
    logic        flg_complete;
`ifdef SRAMADDRESS_PARITY_EN
    logic        flg_parity_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  m_mem [4];
    logic [31:0] m_dout;
    logic        m_flag;
    logic        m_prev_r;
    logic        m_prev_w;

    sram_address dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .WL           (WL),
        .byte_sel     (byte_sel),
        .datain       (datain),
        .read_pulse   (read_pulse),
        .write_pulse  (write_pulse),
        .dataout      (dataout),
`ifdef SRAMADDRESS_PARITY_EN
        .flg_parity_err(flg_parity_err),
`endif
        .flg_complete (flg_complete)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;
        m_dout   = '0;
        m_flag   = 1'b0;
        m_prev_r = 1'b0;
        m_prev_w = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
    task automatic apply(input logic rp, input logic wp, input logic wl,
                         input logic [3:0] bs, input logic [31:0] din);
        logic wev, rev;
        read_pulse  = rp;
        write_pulse = wp;
        WL          = wl;
        byte_sel    = bs;
        datain      = din;
        wev = wp && !m_prev_w && wl;
        rev = rp && !m_prev_r && wl;
        if (wev) begin
            for (int k = 0; k < 4; k++)
                if (bs[k]) m_mem[k] = din[k*8 +: 8];
        end else if (rev) begin
            for (int k = 0; k < 4; k++)
                m_dout[k*8 +: 8] = bs[k] ? m_mem[k] : 8'h00;
        end
        m_flag   = wev || rev;
        m_prev_r = rp;
        m_prev_w = wp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b1, 4'hF, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dataout !== 32'h0 || flg_complete !== 1'b0) begin
            $display("FAIL reset: dataout=%h flag=%b, required 00000000/0", dataout, flg_complete);
            miscompares++;
        end
        #2 rst_n = 1'b1;
        idle();
    endtask

    task automatic test_first_read();
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (dataout !== 32'h0 || flg_complete !== 1'b1) begin
            $display("FAIL first_read: dataout=%h flag=%b, required 00000000/1", dataout, flg_complete);
            miscompares++;
        end
        idle();
        vectors++;
        if (flg_complete !== 1'b0) begin
            $display("FAIL first_read_strobe: flag=%b, required 0", flg_complete);
            miscompares++;
        end
    endtask

    task automatic test_full_write();
        apply(1'b0, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF);
        vectors++;
        if (flg_complete !== 1'b1 || dataout !== 32'h0) begin
            $display("FAIL write_full: flag=%b dataout=%h, required 1/00000000", flg_complete, dataout);
            miscompares++;
        end
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (dataout !== 32'hDEADBEEF) begin
            $display("FAIL read_full: got %h, required DEADBEEF", dataout);
            miscompares++;
        end
        idle();
        apply(1'b1, 1'b0, 1'b1, 4'b0101, 32'h0);
        vectors++;
        if (dataout !== 32'h00AD00EF) begin
            $display("FAIL read_masked: got %h, required 00AD00EF", dataout);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_byte_write();
        apply(1'b0, 1'b1, 1'b1, 4'b0010, 32'h11223344);
        idle();
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (dataout !== 32'hDEAD33EF) begin
            $display("FAIL byte_write: got %h, required DEAD33EF", dataout);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_wl_low();
        apply(1'b0, 1'b1, 1'b0, 4'hF, 32'h12345678);
        vectors++;
        if (flg_complete !== 1'b0) begin
            $display("FAIL wl_low_flag: flag=%b, required 0", flg_complete);
            miscompares++;
        end
        idle();
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (dataout !== 32'hDEAD33EF) begin
            $display("FAIL wl_low_data: got %h, required DEAD33EF", dataout);
            miscompares++;
        end
        idle();
        // Pulse rises while WL low, then WL rises with pulse still high: no access.
        apply(1'b1, 1'b0, 1'b0, 4'hF, 32'h0);
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (flg_complete !== 1'b0) begin
            $display("FAIL wl_raise_late: flag=%b, required 0", flg_complete);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_hold();
        int strobes = 0;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
            if (flg_complete === 1'b1) strobes++;
        end
        idle();
        if (flg_complete === 1'b1) strobes++;
        vectors++;
        if (strobes != 1) begin
            $display("FAIL hold_read: strobes=%0d, required 1", strobes);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D);
        vectors++;
        if (dataout !== 32'hDEAD33EF || flg_complete !== 1'b1) begin
            $display("FAIL simultaneous: dataout=%h flag=%b, required DEAD33EF/1", dataout, flg_complete);
            miscompares++;
        end
        idle();
        vectors++;
        if (flg_complete !== 1'b0) begin
            $display("FAIL simultaneous_strobe: flag=%b, required 0", flg_complete);
            miscompares++;
        end
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (dataout !== 32'hCAFEF00D) begin
            $display("FAIL simultaneous_store: got %h, required CAFEF00D", dataout);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_zero_mask();
        apply(1'b0, 1'b1, 1'b1, 4'h0, 32'hFFFFFFFF);
        vectors++;
        if (flg_complete !== 1'b1) begin
            $display("FAIL zero_mask_write: flag=%b, required 1", flg_complete);
            miscompares++;
        end
        idle();
        apply(1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
        vectors++;
        if (dataout !== 32'h0 || flg_complete !== 1'b1) begin
            $display("FAIL zero_mask_read: dataout=%h flag=%b, required 00000000/1", dataout, flg_complete);
            miscompares++;
        end
        idle();
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (dataout !== 32'hCAFEF00D) begin
            $display("FAIL zero_mask_keep: got %h, required CAFEF00D", dataout);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_mid_reset();
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dataout !== 32'h0 || flg_complete !== 1'b0) begin
            $display("FAIL mid_reset: dataout=%h flag=%b, required 00000000/0", dataout, flg_complete);
            miscompares++;
        end
        #2 rst_n = 1'b1;
        // read_pulse still high: counts as a fresh edge after reset.
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (flg_complete !== 1'b1 || dataout !== 32'h0) begin
            $display("FAIL post_reset_edge: flag=%b dataout=%h, required 1/00000000", flg_complete, dataout);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom);
            vectors++;
            if (dataout !== m_dout || flg_complete !== m_flag) begin
                $display("FAIL random[%0d]: dataout=%h flag=%b, required %h/%b",
                         i, dataout, flg_complete, m_dout, m_flag);
                miscompares++;
            end
        end
        idle();
    endtask

`ifdef SRAMADDRESS_PARITY_EN
    task automatic test_parity();
        apply(1'b0, 1'b1, 1'b1, 4'hF, 32'hA5A5A5A5);
        idle();
        apply(1'b1, 1'b0, 1'b1, 4'hF, 32'h0);
        vectors++;
        if (flg_parity_err !== 1'b0) begin
            $display("FAIL parity_clean: err=%b, required 0", flg_parity_err);
            miscompares++;
        end
        idle();
        force dut.mem_word = 32'hA5A5A5A4;
        apply(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0);
        vectors++;
        if (flg_parity_err !== 1'b1) begin
            $display("FAIL parity_flip: err=%b, required 1", flg_parity_err);
            miscompares++;
        end
        release dut.mem_word;
        idle();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_first_read();
        test_full_write();
        test_byte_write();
        test_wl_low();
        test_hold();
        test_back_to_back();
        test_zero_mask();
        test_mid_reset();
        test_random();
`ifdef SRAMADDRESS_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
